// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single SRAM controller (port 0 = fetch, port 1 = MEM cache).
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority, port 1 first.
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WDATA_W = 32,
  parameter int unsigned RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_rd_en,
  input  logic               p0_wr_en,
  input  logic [ADDR_W-1:0]  p0_address,
  input  logic [WDATA_W-1:0] p0_wdata,
  output logic [RDATA_W-1:0] p0_rdata,
  output logic               p0_ready,
  input  logic               p1_rd_en,
  input  logic               p1_wr_en,
  input  logic [ADDR_W-1:0]  p1_address,
  input  logic [WDATA_W-1:0] p1_wdata,
  output logic [RDATA_W-1:0] p1_rdata,
  output logic               p1_ready,
  output logic               sram_rd_en,
  output logic               sram_wr_en,
  output logic [ADDR_W-1:0]  sram_address,
  output logic [WDATA_W-1:0] sram_wdata,
  input  logic [RDATA_W-1:0] sram_rdata,
  input  logic               sram_ready,
  output logic               grant,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e               r_state, w_state_next;
  logic                 r_grant;
  logic                 r_op_rd, r_op_wr;
  logic [ADDR_W-1:0]    r_addr;
  logic [WDATA_W-1:0]   r_wdata;

  logic w_req0, w_req1, w_winner, w_accept, w_done;

  assign w_req0 = p0_rd_en | p0_wr_en;
  assign w_req1 = p1_rd_en | p1_wr_en;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // On a tie, the port that was not served last goes next.
  assign w_winner = (w_req0 && w_req1) ? ~r_grant : w_req1;
`else
  assign w_winner = w_req1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_grant <= 1'b0;
      r_op_rd <= 1'b0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_grant <= w_winner;
        // A simultaneous read+write on one port is performed as a write.
        if (w_winner) begin
          r_op_wr <= p1_wr_en;
          r_op_rd <= p1_rd_en & ~p1_wr_en;
          r_addr  <= p1_address;
          r_wdata <= p1_wdata;
        end else begin
          r_op_wr <= p0_wr_en;
          r_op_rd <= p0_rd_en & ~p0_wr_en;
          r_addr  <= p0_address;
          r_wdata <= p0_wdata;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req0 || w_req1) begin
          w_accept     = 1'b1;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        sram_rd_en = r_op_rd;
        sram_wr_en = r_op_wr;
        if (sram_ready) begin
          w_done       = ~rst;
          w_state_next = StRelease;
        end
      end
      StRelease: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  assign sram_address = r_addr;
  assign sram_wdata   = r_wdata;
  assign grant        = r_grant;
  assign busy         = (r_state != StIdle);

  assign p0_ready = w_done & ~r_grant;
  assign p1_ready = w_done & r_grant;
  assign p0_rdata = p0_ready ? sram_rdata : '0;
  assign p1_rdata = p1_ready ? sram_rdata : '0;

endmodule
